qupls_checkpoint_ctrl: RTL and testbench

QUPLS_CHECKPOINT_CTRL -- requirements
Module: Qupls_checkpoint_ctrl

---
 rtl/qupls_checkpoint_ctrl.sv | 80 ++++++++
 tb/tb_qupls_checkpoint_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_checkpoint_ctrl.sv
// Checkpoint allocator for branch rename-map snapshots: hands out checkpoints in
// ring order, retires them on branch commit, and rolls back on a branch miss.
module qupls_checkpoint_ctrl #(
  parameter int NCHECK = 16,
  parameter int CBIT   = $clog2(NCHECK)
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            alloc_req,
  output logic            alloc_ack,
  output logic [CBIT-1:0] alloc_cp,
  output logic            stallq,
  input  logic            cmt_br,
  input  logic            restore,
  input  logic [CBIT-1:0] miss_cp,
  output logic [CBIT-1:0] cndx,
  output logic [CBIT-1:0] head,
  output logic [CBIT:0]   nob,
  output logic            copy_req,
  output logic [CBIT-1:0] copy_src,
  output logic [CBIT-1:0] copy_dst,
  output logic            err
);

  logic            full;
  logic            cmt_ok;
  logic [CBIT-1:0] head_nxt;
  logic [CBIT:0]   nob_cmt;
  logic [CBIT-1:0] miss_dist;
  logic            restore_ok;

  // Full is judged on the registered count, so a same-cycle commit never frees a slot early.
  assign full      = (nob == (CBIT+1)'(NCHECK-1));
  assign alloc_ack = alloc_req & ~full & ~restore;
  assign stallq    = alloc_req & full & ~restore;
  assign alloc_cp  = cndx + {{(CBIT-1){1'b0}}, 1'b1};

  // A restore target is checked against the live window as it stands after any same-cycle commit.
  assign cmt_ok     = cmt_br & (nob != '0);
  assign head_nxt   = head + {{(CBIT-1){1'b0}}, cmt_ok};
  assign nob_cmt    = nob - {{CBIT{1'b0}}, cmt_ok};
  assign miss_dist  = miss_cp - head_nxt;
  assign restore_ok = ({1'b0, miss_dist} <= nob_cmt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cndx     <= '0;
      head     <= '0;
      nob      <= '0;
      copy_req <= 1'b0;
      copy_src <= '0;
      copy_dst <= '0;
      err      <= 1'b0;
    end else begin
      head <= head_nxt;
      if (cmt_br & ~cmt_ok)
        err <= 1'b1;
      if (restore) begin
        if (restore_ok) begin
          cndx <= miss_cp;
          nob  <= {1'b0, miss_dist};
        end else begin
          err <= 1'b1;
          nob <= nob_cmt;
        end
      end else if (alloc_ack) begin
        cndx <= alloc_cp;
        nob  <= nob_cmt + {{CBIT{1'b0}}, 1'b1};
      end else begin
        nob <= nob_cmt;
      end
      copy_req <= alloc_ack;
      if (alloc_ack) begin
        copy_src <= cndx;
        copy_dst <= alloc_cp;
      end
    end
  end

endmodule

// File: tb/tb_qupls_checkpoint_ctrl.sv
// Bench for qupls_checkpoint_ctrl: a directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based model of the live checkpoints.
module tb_qupls_checkpoint_ctrl;

  localparam int NCHECK = 16;
  localparam int CBIT   = 4;

  logic            rst;
  logic            clk;
  logic            alloc_req;
  logic            alloc_ack;
  logic [CBIT-1:0] alloc_cp;
  logic            stallq;
  logic            cmt_br;
  logic            restore;
  logic [CBIT-1:0] miss_cp;
  logic [CBIT-1:0] cndx;
  logic [CBIT-1:0] head;
  logic [CBIT:0]   nob;
  logic            copy_req;
  logic [CBIT-1:0] copy_src;
  logic [CBIT-1:0] copy_dst;
  logic            err;

  int checks = 0;
  int passes = 0;

  qupls_checkpoint_ctrl #(.NCHECK(NCHECK)) dut (
    .rst      (rst),
    .clk      (clk),
    .alloc_req(alloc_req),
    .alloc_ack(alloc_ack),
    .alloc_cp (alloc_cp),
    .stallq   (stallq),
    .cmt_br   (cmt_br),
    .restore  (restore),
    .miss_cp  (miss_cp),
    .cndx     (cndx),
    .head     (head),
    .nob      (nob),
    .copy_req (copy_req),
    .copy_src (copy_src),
    .copy_dst (copy_dst),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a, c, r;
    int   m;
    int   e_ack, e_stall, e_cp;
    int   e_cndx, e_head, e_nob, e_err, e_copy;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive inputs mid-cycle so they are stable well before the next rising edge.
  task automatic applyStimulus(input logic a, input logic c, input logic r, input int m);
    @(negedge clk);
    alloc_req = a;
    cmt_br    = c;
    restore   = r;
    miss_cp   = m[CBIT-1:0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    alloc_req = 1'b0; cmt_br = 1'b0; restore = 1'b0; miss_cp = '0;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: the live checkpoints as an ordered queue, oldest first.
  int live[$];
  int m_err, m_copy, m_src, m_dst;

  task automatic modelReset();
    live.delete();
    live.push_back(0);
    m_err = 0; m_copy = 0; m_src = 0; m_dst = 0;
  endtask

  task automatic modelStep(input int a, input int c, input int r, input int m);
    int ack;
    int found;
    ack = a && (live.size() < NCHECK) && !r;
    if (c) begin
      if (live.size() > 1) void'(live.pop_front());
      else m_err = 1;
    end
    if (r) begin
      found = -1;
      foreach (live[i]) if (live[i] == m) found = i;
      if (found < 0) m_err = 1;
      else while (live.size() > found + 1) void'(live.pop_back());
    end
    m_copy = ack;
    if (ack) begin
      m_src = live[live.size()-1];
      m_dst = (m_src + 1) % NCHECK;
      live.push_back(m_dst);
    end
  endtask

  initial begin
    int a, c, r, m, exp_full;
    rst = 1'b1;
    alloc_req = 1'b0; cmt_br = 1'b0; restore = 1'b0; miss_cp = '0;

    // Reset state, including combinational outputs while reset is held.
    #2;
    alloc_req = 1'b1;
    #1;
    checkOutput("rst_cndx", cndx, 0);
    checkOutput("rst_head", head, 0);
    checkOutput("rst_nob", nob, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_copy_req", copy_req, 0);
    checkOutput("rst_copy_src", copy_src, 0);
    checkOutput("rst_copy_dst", copy_dst, 0);
    checkOutput("rst_alloc_ack", alloc_ack, 1);
    checkOutput("rst_stallq", stallq, 0);
    alloc_req = 1'b0;
    doReset();

    // Directed table: inputs, comb outputs before the edge, state after it.
    vecs[0]  = '{1,0,0,0,  1,0,1,  1,0,1,0,1};
    vecs[1]  = '{1,0,0,0,  1,0,2,  2,0,2,0,1};
    vecs[2]  = '{1,0,0,0,  1,0,3,  3,0,3,0,1};
    vecs[3]  = '{1,1,0,0,  1,0,4,  4,1,3,0,1};
    vecs[4]  = '{0,1,0,0,  0,0,5,  4,2,2,0,0};
    vecs[5]  = '{1,0,0,0,  1,0,5,  5,2,3,0,1};
    vecs[6]  = '{1,0,0,0,  1,0,6,  6,2,4,0,1};
    vecs[7]  = '{1,0,1,4,  0,0,7,  4,2,2,0,0};
    vecs[8]  = '{0,0,1,9,  0,0,5,  4,2,2,1,0};
    vecs[9]  = '{0,1,1,2,  0,0,5,  4,3,1,1,0};
    vecs[10] = '{0,1,1,4,  0,0,5,  4,4,0,1,0};
    vecs[11] = '{0,1,0,0,  0,0,5,  4,4,0,1,0};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].c, vecs[i].r, vecs[i].m);
      checkOutput($sformatf("vec%0d_ack", i), alloc_ack, vecs[i].e_ack);
      checkOutput($sformatf("vec%0d_stallq", i), stallq, vecs[i].e_stall);
      checkOutput($sformatf("vec%0d_alloc_cp", i), alloc_cp, vecs[i].e_cp);
      tick();
      checkOutput($sformatf("vec%0d_cndx", i), cndx, vecs[i].e_cndx);
      checkOutput($sformatf("vec%0d_head", i), head, vecs[i].e_head);
      checkOutput($sformatf("vec%0d_nob", i), nob, vecs[i].e_nob);
      checkOutput($sformatf("vec%0d_err", i), err, vecs[i].e_err);
      checkOutput($sformatf("vec%0d_copy_req", i), copy_req, vecs[i].e_copy);
    end

    // Fill to capacity, then stall; a same-cycle commit must not relieve full.
    doReset();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput($sformatf("fill%0d_ack", i), alloc_ack, 1);
      checkOutput($sformatf("fill%0d_cp", i), alloc_cp, i);
      tick();
    end
    checkOutput("full_cndx", cndx, 15);
    checkOutput("full_nob", nob, 15);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_stallq", stallq, 1);
    checkOutput("full_ack", alloc_ack, 0);
    tick();
    applyStimulus(1, 1, 0, 0);
    checkOutput("fullcmt_stallq", stallq, 1);
    checkOutput("fullcmt_ack", alloc_ack, 0);
    tick();
    checkOutput("fullcmt_head", head, 1);
    checkOutput("fullcmt_nob", nob, 14);
    checkOutput("fullcmt_cndx", cndx, 15);
    applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_ack", alloc_ack, 1);
    checkOutput("wrap_cp", alloc_cp, 0);
    tick();
    checkOutput("wrap_cndx", cndx, 0);
    checkOutput("wrap_nob", nob, 15);
    checkOutput("wrap_copy_src", copy_src, 15);
    checkOutput("wrap_copy_dst", copy_dst, 0);

    // Commit with nothing outstanding, then a copy pulse from cndx=3.
    doReset();
    for (int i = 0; i < 3; i++) begin applyStimulus(1, 0, 0, 0); tick(); end
    for (int i = 0; i < 3; i++) begin applyStimulus(0, 1, 0, 0); tick(); end
    checkOutput("under_err_before", err, 0);
    applyStimulus(0, 1, 0, 0);
    tick();
    checkOutput("under_err", err, 1);
    checkOutput("under_head", head, 3);
    checkOutput("under_nob", nob, 0);
    applyStimulus(1, 0, 0, 0);
    tick();
    checkOutput("copy_req", copy_req, 1);
    checkOutput("copy_src", copy_src, 3);
    checkOutput("copy_dst", copy_dst, 4);
    checkOutput("err_sticky", err, 1);
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("copy_req_drop", copy_req, 0);
    checkOutput("copy_src_hold", copy_src, 3);
    checkOutput("copy_dst_hold", copy_dst, 4);

    // Asynchronous reset between edges while a copy pulse is showing.
    applyStimulus(1, 0, 0, 0);
    @(posedge clk);
    #2;
    checkOutput("async_pre_copy", copy_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_copy_req", copy_req, 0);
    checkOutput("async_nob", nob, 0);
    checkOutput("async_cndx", cndx, 0);
    checkOutput("async_head", head, 0);
    checkOutput("async_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    alloc_req = 1'b0;

    // Randomized run against the queue model.
    doReset();
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 99) < 65) ? 1 : 0;
      c = ($urandom_range(0, 99) < 40) ? 1 : 0;
      r = ($urandom_range(0, 99) < 8) ? 1 : 0;
      m = $urandom_range(0, NCHECK-1);
      if (n % 700 == 699) begin
        doReset();
        modelReset();
      end
      applyStimulus(a[0], c[0], r[0], m);
      exp_full = (live.size() == NCHECK) ? 1 : 0;
      checkOutput("rnd_ack", alloc_ack, (a && !exp_full && !r) ? 1 : 0);
      checkOutput("rnd_stallq", stallq, (a && exp_full && !r) ? 1 : 0);
      checkOutput("rnd_alloc_cp", alloc_cp, (live[live.size()-1] + 1) % NCHECK);
      modelStep(a, c, r, m);
      tick();
      checkOutput("rnd_cndx", cndx, live[live.size()-1]);
      checkOutput("rnd_head", head, live[0]);
      checkOutput("rnd_nob", nob, live.size() - 1);
      checkOutput("rnd_err", err, m_err);
      checkOutput("rnd_copy_req", copy_req, m_copy);
      checkOutput("rnd_copy_src", copy_src, m_src);
      checkOutput("rnd_copy_dst", copy_dst, m_dst);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
